capture_buffer: RTL and testbench
=================================

// Module: capture_buffer
// PURPOSE
//  AXI-stream slave that sinks the sample stream from the capture front end into an on-chip circular RAM.
//  - Keeps pre-trigger history while armed.
//  - Stores a programmable number of post-trigger samples, then freezes.
//  - Exposes the frozen record through a random-access read port for the host interface.
// PARAMETERS
//  size   32    sample width, bits
//  depth  1024  buffer entries; power of two, >=4; aw = $clog2(depth)
// PORTS
//  clk         in   1     system clock; all logic on posedge
//  reset       in   1     asynchronous, active-low reset
//  s_tdata     in   size  sample data
//  s_tvalid    in   1     sample valid
//  s_tready    out  1     buffer accepting samples
//  arm         in   1     capture enable, level
//  abort       in   1     cancel capture, level, highest priority
//  triggered   in   1     trigger flag, already synchronized to clk, level
//  post_count  in   aw    samples stored after the trigger sample
//  done        out  1     record frozen and readable
//  busy        out  1     state is PRE or POST
//  count       out  aw+1  valid entries in record (1..depth)
//  trig_index  out  aw    logical index of trigger sample in record
//  rd_en       in   1     read strobe
//  rd_addr     in   aw    logical index, 0 = oldest sample
//  rd_data     out  size  read data, registered
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; wr_ptr=0, fill=0.
//  States: IDLE, PRE, POST, DONE.
//  Beat: s_tvalid && s_tready. s_tready=1 only in PRE and POST.
//  Arm: rising edge of arm (arm && !arm_q) in IDLE or DONE -> PRE.
//   - Clears wr_ptr, fill, done.
//   - Beats are not accepted in the arming cycle.
//  PRE:
//   - Each beat writes mem[wr_ptr]; wr_ptr = (wr_ptr+1) mod depth (wraps).
//   - fill increments, saturating at depth.
//   - If triggered=1 in a cycle: trig_ptr = wr_ptr; rem = post_count; -> POST.
//   - If that cycle also carries a beat, that beat is the trigger sample. Otherwise the next beat is.
//  POST:
//   - The trigger sample is written first, with no decrement.
//   - Each following beat writes and decrements rem.
//   - When rem==0 and the trigger sample is stored -> DONE next cycle.
//   - post_count=0 -> DONE right after the trigger sample.
//   - post_count >= depth-fill_at_trigger overwrites the oldest history.
//   - trig_ptr is never overwritten (post_count <= depth-1).
//  DONE:
//   - s_tready=0, done=1.
//   - start = (fill==depth) ? wr_ptr : 0.
//   - count = fill.
//   - trig_index = (trig_ptr - start) mod depth.
//  Cancel:
//   - abort=1 in any state -> IDLE next edge; done=0; record discarded.
//   - arm falling while in PRE or POST behaves the same as abort.
//   - arm falling while in DONE keeps the record.
//  Read port:
//   - rd_en with rd_addr=a -> rd_data = mem[(start+a) mod depth] on the following cycle (1-cycle latency).
//   - rd_data holds its value when rd_en=0.
//   - Reads outside DONE return 0.
//   - a >= count returns stale RAM contents, no error.
//  RAM: single write port, single read port; write and read never collide in DONE.
//  Simultaneous events:
//   - abort beats arm-edge and trigger.
//   - trigger on the last beat of PRE is legal.
//   - An arm edge in DONE restarts the capture.
// CONFIGURATION
//  CAPTURE_BUFFER_SAMPLE_CNT_EN defined:
//   - Adds output sample_cnt [31:0]: total beats accepted since the last arm edge.
//   - Counts across wrap, saturates at 2^32-1, cleared by reset and by each arm edge.
//  Undefined: port and counter absent; all other behaviour identical.
// TESTING
//  1. depth=16, arm, 5 beats (0..4), trigger at beat 2, post_count=2
//     -> done; count=5; trig_index=2; rd 0..4 = 0..4.
//  2. depth=16, 40 beats (0..39) in PRE, trigger at beat 40, post_count=3
//     -> count=16; rd0=28; trig_index=12; rd15=43.
//  3. post_count=0, trigger with no beat, then one beat 0xA5
//     -> DONE after that beat; rd[trig_index]=0xA5.
//  4. abort mid-POST
//     -> IDLE next cycle; s_tready=0; done=0; re-arm restarts fill=0.
//  5. DONE then 10 beats offered
//     -> s_tready=0, record unchanged; rd latency exactly 1 cycle, rd_data held.
//  6. Macro on, 20 beats, trigger, post 4 -> sample_cnt=25; reset mid-PRE -> all outputs 0.

Source files
------------

// File: rtl/capture_buffer.sv
// rtl/capture_buffer.sv - circular capture buffer with pre/post-trigger record and random-access read port
//
// Sinks an AXI-stream sample stream into a circular RAM. While armed it keeps
// pre-trigger history, then stores post_count samples after the trigger sample
// and freezes the record for random-access readout.
//
// Ports:
//   clk, reset            clock (posedge) and asynchronous active-low reset
//   s_tdata/s_tvalid/s_tready  sample stream slave; ready only while capturing
//   arm                   capture enable level; rising edge starts, falling edge cancels a capture
//   abort                 cancel level, highest priority
//   triggered             synchronous trigger level
//   post_count            samples stored after the trigger sample
//   done, busy            record frozen / capture in progress
//   count, trig_index     valid entries and trigger position in the frozen record
//   rd_en, rd_addr, rd_data  logical read port, 0 = oldest sample, 1-cycle latency
//
// Optional feature macro: CAPTURE_BUFFER_SAMPLE_CNT_EN adds sample_cnt[31:0],
// the saturating number of beats accepted since the last arm edge.

module capture_buffer #(
   parameter int size  = 32,
   parameter int depth = 1024,
   localparam int aw   = $clog2(depth)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [size-1:0] s_tdata,
   input  logic            s_tvalid,
   output logic            s_tready,
   input  logic            arm,
   input  logic            abort,
   input  logic            triggered,
   input  logic [aw-1:0]   post_count,
   output logic            done,
   output logic            busy,
   output logic [aw:0]     count,
   output logic [aw-1:0]   trig_index,
`ifdef CAPTURE_BUFFER_SAMPLE_CNT_EN
   output logic [31:0]     sample_cnt,
`endif
   input  logic            rd_en,
   input  logic [aw-1:0]   rd_addr,
   output logic [size-1:0] rd_data
);

   typedef enum logic [1:0] {IDLE, PRE, POST, DONE} state_t;

   localparam logic [aw:0] FULL = (aw+1)'(depth);

   state_t          state_q, state_d;
   logic [aw-1:0]   wr_ptr_q, wr_ptr_d;
   logic [aw:0]     fill_q, fill_d;
   logic [aw-1:0]   trig_ptr_q, trig_ptr_d;
   logic [aw-1:0]   rem_q, rem_d;
   logic            trig_seen_q, trig_seen_d;   // trigger sample already written
   logic            arm_q;
   logic [size-1:0] rd_data_q;
   logic            wr_en;

   logic [size-1:0] mem [depth];

   logic            arm_rise, arm_fall, beat;
   logic [aw-1:0]   start;
   logic [aw-1:0]   rd_idx;

   assign arm_rise = arm && !arm_q;
   assign arm_fall = !arm && arm_q;
   assign s_tready = (state_q == PRE) || (state_q == POST);
   assign beat     = s_tvalid && s_tready;

   // Once the buffer has wrapped, the oldest sample sits at the write pointer.
   assign start  = (fill_q == FULL) ? wr_ptr_q : '0;
   assign rd_idx = start + rd_addr;

   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      fill_d      = fill_q;
      trig_ptr_d  = trig_ptr_q;
      rem_d       = rem_q;
      trig_seen_d = trig_seen_q;
      wr_en       = 1'b0;

      if (abort) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               // Falling arm in DONE keeps the record; only a new edge restarts.
               if (arm_rise) begin
                  state_d  = PRE;
                  wr_ptr_d = '0;
                  fill_d   = '0;
               end
            end
            PRE: begin
               if (arm_fall) begin
                  state_d = IDLE;
               end else begin
                  if (beat) begin
                     wr_en    = 1'b1;
                     wr_ptr_d = wr_ptr_q + 1'b1;
                     if (fill_q != FULL) fill_d = fill_q + 1'b1;
                  end
                  if (triggered) begin
                     trig_ptr_d  = wr_ptr_q;
                     rem_d       = post_count;
                     trig_seen_d = beat;
                     state_d     = (beat && post_count == '0) ? DONE : POST;
                  end
               end
            end
            POST: begin
               if (arm_fall) begin
                  state_d = IDLE;
               end else if (beat) begin
                  wr_en    = 1'b1;
                  wr_ptr_d = wr_ptr_q + 1'b1;
                  if (fill_q != FULL) fill_d = fill_q + 1'b1;
                  if (!trig_seen_q) begin
                     trig_seen_d = 1'b1;
                     if (rem_q == '0) state_d = DONE;
                  end else begin
                     rem_d = rem_q - 1'b1;
                     // Freeze on the beat that consumes the last remaining slot.
                     if (rem_q == aw'(1)) state_d = DONE;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         wr_ptr_q    <= '0;
         fill_q      <= '0;
         trig_ptr_q  <= '0;
         rem_q       <= '0;
         trig_seen_q <= 1'b0;
         arm_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         fill_q      <= fill_d;
         trig_ptr_q  <= trig_ptr_d;
         rem_q       <= rem_d;
         trig_seen_q <= trig_seen_d;
         arm_q       <= arm;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr_q] <= s_tdata;
   end

   // Writes only happen in PRE/POST, so the read in DONE never collides.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_data_q <= '0;
      end else if (rd_en) begin
         rd_data_q <= (state_q == DONE) ? mem[rd_idx] : '0;
      end
   end

`ifdef CAPTURE_BUFFER_SAMPLE_CNT_EN
   logic [31:0] sample_cnt_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sample_cnt_q <= '0;
      end else if (arm_rise) begin
         sample_cnt_q <= '0;
      end else if (beat && sample_cnt_q != 32'hFFFF_FFFF) begin
         sample_cnt_q <= sample_cnt_q + 32'd1;
      end
   end

   assign sample_cnt = sample_cnt_q;
`endif

   assign done       = (state_q == DONE);
   assign busy       = s_tready;
   assign count      = done ? fill_q : '0;
   assign trig_index = done ? (trig_ptr_q - start) : '0;
   assign rd_data    = rd_data_q;

endmodule

// File: tb/tb_capture_buffer.sv
// tb/tb_capture_buffer.sv - randomized self-checking bench for capture_buffer against a sample-list model
module tb_capture_buffer;
   localparam int SIZE  = 32;
   localparam int DEPTH = 16;
   localparam int AW    = 4;

   logic            clk = 1'b0;
   logic            reset = 1'b0;
   logic [SIZE-1:0] s_tdata = '0;
   logic            s_tvalid = 1'b0;
   logic            s_tready;
   logic            arm = 1'b0;
   logic            abort = 1'b0;
   logic            triggered = 1'b0;
   logic [AW-1:0]   post_count = '0;
   logic            done;
   logic            busy;
   logic [AW:0]     count;
   logic [AW-1:0]   trig_index;
   logic            rd_en = 1'b0;
   logic [AW-1:0]   rd_addr = '0;
   logic [SIZE-1:0] rd_data;
`ifdef CAPTURE_BUFFER_SAMPLE_CNT_EN
   logic [31:0]     sample_cnt;
`endif

   int vectors = 0;
   int miscompares = 0;

   // Model: every accepted sample since the arm edge, and the trigger sample's position.
   logic [31:0] q[$];
   int          trigpos;

   capture_buffer #(.size(SIZE), .depth(DEPTH)) dut (
      .clk(clk), .reset(reset),
      .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
      .arm(arm), .abort(abort), .triggered(triggered), .post_count(post_count),
      .done(done), .busy(busy), .count(count), .trig_index(trig_index),
`ifdef CAPTURE_BUFFER_SAMPLE_CNT_EN
      .sample_cnt(sample_cnt),
`endif
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_beat(input logic [31:0] d);
      s_tvalid = 1'b1;
      s_tdata  = d;
      vectors++;
      if (s_tready !== 1'b1) begin
         miscompares++;
         $display("FAIL beat_ready got %0b exp 1", s_tready);
      end
      q.push_back(d);
      step();
   endtask

   // Runs one complete capture, then checks the frozen record against the model.
   task automatic capture(input int n_pre, input bit trig_beat, input int post,
                          input bit seq, input bit gaps);
      int k;
      int n, cnt, off, base;
      k = 0;
      post_count = AW'(post);
      arm = 1'b0; step();
      arm = 1'b1; step();
      q.delete();
      vectors++;
      if (busy !== 1'b1 || s_tready !== 1'b1 || done !== 1'b0) begin
         miscompares++;
         $display("FAIL armed busy=%0b rdy=%0b done=%0b exp 1 1 0", busy, s_tready, done);
      end
      for (int i = 0; i < n_pre; i++) begin
         if (gaps && $urandom_range(0, 2) == 0) begin s_tvalid = 1'b0; step(); end
         push_beat(seq ? 32'(k) : $urandom); k++;
      end
      triggered = 1'b1;
      if (!trig_beat) begin
         s_tvalid = 1'b0; step();
         triggered = 1'b0;
         if (gaps && $urandom_range(0, 1) == 0) step();
      end
      trigpos = q.size();
      push_beat(seq ? 32'(k) : $urandom); k++;
      triggered = 1'b0;
      for (int i = 0; i < post; i++) begin
         if (gaps && $urandom_range(0, 2) == 0) begin s_tvalid = 1'b0; step(); end
         push_beat(seq ? 32'(k) : $urandom); k++;
      end
      s_tvalid = 1'b0;
      n   = q.size();
      cnt = (n < DEPTH) ? n : DEPTH;
      off = n - cnt;
      vectors++;
      if (done !== 1'b1 || busy !== 1'b0 || s_tready !== 1'b0) begin
         miscompares++;
         $display("FAIL frozen done=%0b busy=%0b rdy=%0b exp 1 0 0", done, busy, s_tready);
      end
      vectors++;
      if (count !== (AW+1)'(cnt)) begin
         miscompares++;
         $display("FAIL count got %0d exp %0d", count, cnt);
      end
      vectors++;
      if (trig_index !== AW'(trigpos - off)) begin
         miscompares++;
         $display("FAIL trig_index got %0d exp %0d", trig_index, trigpos - off);
      end
      base = $urandom_range(0, cnt - 1);
      for (int i = 0; i < cnt; i++) begin
         int a;
         a = (base + i) % cnt;
         rd_en = 1'b1; rd_addr = AW'(a);
         step();
         vectors++;
         if (rd_data !== q[off + a]) begin
            miscompares++;
            $display("FAIL rd[%0d] got %h exp %h", a, rd_data, q[off + a]);
         end
      end
      rd_en = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) step();
      vectors++;
      if ({s_tready, done, busy, count, trig_index, rd_data} !== '0) begin
         miscompares++;
         $display("FAIL reset_outputs rdy=%0b done=%0b busy=%0b cnt=%0d ti=%0d rd=%h exp all 0",
                  s_tready, done, busy, count, trig_index, rd_data);
      end
      reset = 1'b1;
      step();
   endtask

   task automatic test_small_record();
      capture(2, 1'b1, 2, 1'b1, 1'b0);
      vectors++;
      if (count !== 5'd5 || trig_index !== 4'd2) begin
         miscompares++;
         $display("FAIL small_record cnt=%0d ti=%0d exp 5 2", count, trig_index);
      end
   endtask

   task automatic test_wrap();
      capture(40, 1'b1, 3, 1'b1, 1'b0);
      vectors++;
      if (count !== 5'd16 || trig_index !== 4'd12) begin
         miscompares++;
         $display("FAIL wrap cnt=%0d ti=%0d exp 16 12", count, trig_index);
      end
   endtask

   task automatic test_post_zero();
      capture($urandom_range(1, 20), 1'b0, 0, 1'b0, 1'b1);
      capture(0, 1'b0, 0, 1'b0, 1'b0);
   endtask

   task automatic test_done_hold();
      logic [31:0] held;
      capture(10, 1'b1, 5, 1'b0, 1'b1);
      for (int i = 0; i < 10; i++) begin
         s_tvalid = 1'b1; s_tdata = $urandom;
         vectors++;
         if (s_tready !== 1'b0 || done !== 1'b1) begin
            miscompares++;
            $display("FAIL done_ready rdy=%0b done=%0b exp 0 1", s_tready, done);
         end
         step();
      end
      s_tvalid = 1'b0;
      arm = 1'b0; step();
      vectors++;
      if (done !== 1'b1 || count !== 5'd16) begin
         miscompares++;
         $display("FAIL arm_fall_done done=%0b cnt=%0d exp 1 16", done, count);
      end
      rd_en = 1'b1; rd_addr = 4'd3; step();
      held = q[q.size() - DEPTH + 3];
      vectors++;
      if (rd_data !== held) begin
         miscompares++;
         $display("FAIL rd_after_beats got %h exp %h", rd_data, held);
      end
      rd_en = 1'b0; rd_addr = 4'd9;
      repeat (3) step();
      vectors++;
      if (rd_data !== held) begin
         miscompares++;
         $display("FAIL rd_hold got %h exp %h", rd_data, held);
      end
   endtask

   task automatic test_abort();
      post_count = 4'd5;
      arm = 1'b0; step();
      arm = 1'b1; step();
      s_tvalid = 1'b1;
      repeat (5) begin s_tdata = $urandom; step(); end
      triggered = 1'b1; step(); triggered = 1'b0;
      step();
      s_tvalid = 1'b0;
      abort = 1'b1; step(); abort = 1'b0;
      vectors++;
      if ({busy, done, s_tready, count, trig_index} !== '0) begin
         miscompares++;
         $display("FAIL abort busy=%0b done=%0b rdy=%0b cnt=%0d exp 0", busy, done, s_tready, count);
      end
      rd_en = 1'b1; rd_addr = 4'd0; step(); rd_en = 1'b0;
      vectors++;
      if (rd_data !== '0) begin
         miscompares++;
         $display("FAIL rd_idle got %h exp 0", rd_data);
      end
      capture(3, 1'b1, 1, 1'b0, 1'b0);
      // Arm falling during PRE cancels like abort.
      arm = 1'b0; step(); arm = 1'b1; step();
      s_tvalid = 1'b1; s_tdata = $urandom; step();
      arm = 1'b0; step(); s_tvalid = 1'b0;
      vectors++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         miscompares++;
         $display("FAIL arm_fall_pre busy=%0b done=%0b exp 0 0", busy, done);
      end
      // Abort wins over a simultaneous arm edge.
      arm = 1'b1; abort = 1'b1; step(); abort = 1'b0;
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("FAIL abort_vs_arm busy=%0b exp 0", busy);
      end
   endtask

   task automatic test_random();
      for (int r = 0; r < 12; r++)
         capture($urandom_range(0, 40), 1'($urandom_range(0, 1)),
                 $urandom_range(0, DEPTH - 1), 1'b0, 1'b1);
   endtask

   task automatic test_count_and_reset();
      capture(20, 1'b1, 4, 1'b1, 1'b0);
`ifdef CAPTURE_BUFFER_SAMPLE_CNT_EN
      vectors++;
      if (sample_cnt !== 32'd25) begin
         miscompares++;
         $display("FAIL sample_cnt got %0d exp 25", sample_cnt);
      end
`endif
      arm = 1'b0; step(); arm = 1'b1; step();
      s_tvalid = 1'b1;
      repeat (4) begin s_tdata = $urandom; step(); end
      reset = 1'b0; #2;
      vectors++;
      if ({s_tready, done, busy, count, trig_index, rd_data} !== '0) begin
         miscompares++;
         $display("FAIL reset_mid_pre rdy=%0b done=%0b busy=%0b cnt=%0d rd=%h exp all 0",
                  s_tready, done, busy, count, rd_data);
      end
`ifdef CAPTURE_BUFFER_SAMPLE_CNT_EN
      vectors++;
      if (sample_cnt !== 32'd0) begin
         miscompares++;
         $display("FAIL reset_sample_cnt got %0d exp 0", sample_cnt);
      end
`endif
      s_tvalid = 1'b0; arm = 1'b0;
      step();
      reset = 1'b1;
      step();
   endtask

   initial begin
      test_reset();
      test_small_record();
      test_wrap();
      test_post_zero();
      test_done_hold();
      test_abort();
      test_random();
      test_count_and_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
